// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the core (A) and the loader (B).
// Registers the winning command, drives the RAM for one cycle per grant, returns read data/err.
module dram_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int DEPTH    = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          a_req,
    input  logic          b_req,
    input  logic          a_we,
    input  logic          b_we,
    input  logic          a_lock,
    input  logic          b_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          a_err,
    output logic          b_err,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int          CW      = $clog2(LOCK_MAX + 1);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            cmd_we, cmd_lock, cmd_inr;
    logic            last_b;
    logic [CW-1:0]   lock_cnt, lock_cnt_nxt;
    logic            any_req;
    logic            win_b, win_we, win_lock, win_inr;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic            a_rv_q, b_rv_q, a_err_q, b_err_q;

    always_comb begin
        any_req = a_req | b_req;
        win_b   = b_req & ~a_req;
        // cmd_lock is cleared on IDLE, so it only reflects a lock carried by the grant just issued
        if (a_req && b_req) begin
            if (cmd_lock && (lock_cnt < CW'(LOCK_MAX)))
                win_b = last_b;
            else
                win_b = ~last_b;
        end
        win_we    = win_b ? b_we    : a_we;
        win_lock  = win_b ? b_lock  : a_lock;
        win_addr  = win_b ? b_addr  : a_addr;
        win_wdata = win_b ? b_wdata : a_wdata;
        win_inr   = ({1'b0, win_addr} < DEPTH_W);

        state_nxt = IDLE;
        if (any_req)
            state_nxt = win_b ? GRANT_B : GRANT_A;

        lock_cnt_nxt = '0;
        if (any_req && cmd_lock && win_lock && (win_b == last_b))
            lock_cnt_nxt = (lock_cnt == CW'(LOCK_MAX)) ? lock_cnt : lock_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            lock_cnt <= '0;
            last_b   <= 1'b1;
            cmd_we   <= 1'b0;
            cmd_lock <= 1'b0;
            cmd_inr  <= 1'b0;
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            a_rv_q   <= 1'b0;
            b_rv_q   <= 1'b0;
            a_err_q  <= 1'b0;
            b_err_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            cmd_lock <= 1'b0;
            if (any_req) begin
                last_b   <= win_b;
                cmd_we   <= win_we;
                cmd_lock <= win_lock;
                cmd_inr  <= win_inr;
                ram_addr <= win_addr;
                ram_din  <= win_wdata;
                ram_we   <= win_inr & win_we;
                ram_re   <= win_inr & ~win_we;
            end
            a_rv_q  <= (state == GRANT_A) & ~cmd_we;
            a_err_q <= (state == GRANT_A) & ~cmd_inr;
            b_rv_q  <= (state == GRANT_B) & ~cmd_we;
            b_err_q <= (state == GRANT_B) & ~cmd_inr;
        end
    end

    always_comb begin
        a_gnt    = (state == GRANT_A);
        b_gnt    = (state == GRANT_B);
        a_rvalid = a_rv_q;
        b_rvalid = b_rv_q;
        a_err    = a_err_q;
        b_err    = b_err_q;
        a_rdata  = (a_rv_q && !a_err_q) ? ram_dout : '0;
        b_rdata  = (b_rv_q && !b_err_q) ? ram_dout : '0;
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: requester queues drive both ports, a 32x16 RAM model sits on the RAM side,
// and expected grants/responses are queued at grant time and compared against what the DUT produced.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_req, b_req, a_we, b_we, a_lock, b_lock;
    logic [8:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic        ram_we, ram_re;
    logic [8:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    dram_arbiter #(.AW(9), .DW(16), .DEPTH(32), .LOCK_MAX(4)) dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_lock(a_lock), .b_lock(b_lock), .a_addr(a_addr), .b_addr(b_addr),
        .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata), .a_err(a_err), .b_err(b_err),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // RAM model with registered read address and a bench-side preload port
    logic [15:0] mem [32];
    logic [4:0]  rd_addr;
    logic        ld;
    logic [4:0]  ld_addr;
    logic [15:0] ld_data;
    always @(posedge clk) begin
        if (ld) mem[ld_addr] <= ld_data;
        else if (ram_we) mem[ram_addr[4:0]] <= ram_din;
        if (ram_re) rd_addr <= ram_addr[4:0];
    end
    assign ram_dout = mem[rd_addr];

    logic [64:0] all_out;
    assign all_out = {a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, ram_we, ram_re,
                      ram_addr, ram_din, a_rdata, b_rdata};

    typedef struct packed { logic we; logic lock; logic [8:0] addr; logic [15:0] wdata; } cmd_t;
    typedef struct packed { logic port; logic we; logic re; logic [8:0] addr; logic [15:0] din; logic [31:0] cyc; } gnt_t;
    typedef struct packed { logic port; logic rv; logic err; logic [15:0] data; logic [31:0] cyc; } rsp_t;

    cmd_t        a_cmds[$], b_cmds[$];
    gnt_t        gnt_log[$], gnt_exp[$];
    rsp_t        rsp_log[$], rsp_exp[$];
    logic [15:0] exp_mem [32];
    logic [31:0] cyc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic present();
        a_req = (a_cmds.size() != 0);
        b_req = (b_cmds.size() != 0);
        {a_we, a_lock, a_addr, a_wdata} = '0;
        {b_we, b_lock, b_addr, b_wdata} = '0;
        if (a_req) {a_we, a_lock, a_addr, a_wdata} = a_cmds[0];
        if (b_req) {b_we, b_lock, b_addr, b_wdata} = b_cmds[0];
    endtask

    // Requester side of a grant: retire the command and queue what the DUT should do with it
    task automatic take(input logic port);
        cmd_t c;
        logic inr;
        c = '0;
        if (!port && a_cmds.size() != 0) c = a_cmds.pop_front();
        if (port && b_cmds.size() != 0) c = b_cmds.pop_front();
        inr = (c.addr < 9'd32);
        gnt_log.push_back('{port, ram_we, ram_re, ram_addr, ram_din, cyc});
        gnt_exp.push_back('{port, c.we & inr, ~c.we & inr, c.addr, c.wdata, cyc});
        if (!c.we || !inr)
            rsp_exp.push_back('{port, ~c.we, ~inr, (~c.we & inr) ? exp_mem[c.addr[4:0]] : 16'h0, cyc + 1});
        else
            exp_mem[c.addr[4:0]] = c.wdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (a_gnt) take(1'b0);
        if (b_gnt) take(1'b1);
        if (a_rvalid || a_err) rsp_log.push_back('{1'b0, a_rvalid, a_err, a_rdata, cyc});
        if (b_rvalid || b_err) rsp_log.push_back('{1'b1, b_rvalid, b_err, b_rdata, cyc});
        present();
    endtask

    task automatic run(output logic timeout);
        int unsigned n;
        n = 0;
        present();
        while ((a_cmds.size() != 0 || b_cmds.size() != 0) && n < 200) begin
            cycle();
            n++;
        end
        timeout = (n >= 200);
        repeat (3) cycle();
    endtask

    task automatic clear_logs();
        gnt_log.delete(); gnt_exp.delete(); rsp_log.delete(); rsp_exp.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) cycle();
        rstn = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ld = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ld_addr = 5'(i);
            ld_data = (i == 5) ? 16'h1234 : (16'(i) * 16'h0111) ^ 16'h5A5A;
            exp_mem[i] = ld_data;
            cycle();
        end
        ld = 1'b0;
        checks++;
        if (all_out !== 65'd0) begin failures++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({a_gnt, b_gnt, ram_we, ram_re} !== 4'b0000) begin
                failures++; $display("FAIL idle_after_reset%0d: got %b want 0000", i, {a_gnt, b_gnt, ram_we, ram_re});
            end
        end
        a_cmds.push_back('{1'b0, 1'b0, 9'd3, 16'h0});
        present();
        cycle();
        checks++;
        if (a_gnt !== 1'b1) begin failures++; $display("FAIL pre_reset_gnt: got %b want 1", a_gnt); end
        #3 rstn = 1'b0;
        #1;
        checks++;
        if (all_out !== 65'd0) begin failures++; $display("FAIL async_reset_outputs: got %h want 0", all_out); end
        #2 rstn = 1'b1;
        clear_logs();
        repeat (3) cycle();
        checks++;
        if (gnt_log.size() + rsp_log.size() != 0) begin
            failures++; $display("FAIL reset_discard: got %0d events want 0", gnt_log.size() + rsp_log.size());
        end
    endtask

    task automatic test_single_read();
        logic to;
        logic [31:0] start;
        clear_logs();
        start = cyc;
        a_cmds.push_back('{1'b0, 1'b0, 9'd5, 16'h0});
        run(to);
        checks++;
        if (to || gnt_log.size() != 1) begin failures++; $display("FAIL read_grants: got %0d want 1", gnt_log.size()); end
        else begin
            checks++;
            if ({gnt_log[0].port, gnt_log[0].re, gnt_log[0].we, gnt_log[0].addr, gnt_log[0].cyc} !== {3'b010, 9'd5, start + 1}) begin
                failures++; $display("FAIL read_gnt: got port=%b re=%b we=%b addr=%0d cyc=%0d want 0 1 0 5 %0d",
                    gnt_log[0].port, gnt_log[0].re, gnt_log[0].we, gnt_log[0].addr, gnt_log[0].cyc, start + 1);
            end
        end
        checks++;
        if (rsp_log.size() != 1 || rsp_log[0] !== {3'b010, 16'h1234, start + 2}) begin
            failures++; $display("FAIL read_rsp: got n=%0d %h want %h", rsp_log.size(), rsp_log.size() ? rsp_log[0] : '0, {3'b010, 16'h1234, start + 2});
        end
    endtask

    task automatic test_back_to_back();
        logic to;
        int bad;
        clear_logs();
        a_cmds.push_back('{1'b1, 1'b0, 9'd7, 16'hBEEF});
        a_cmds.push_back('{1'b0, 1'b0, 9'd7, 16'h0});
        run(to);
        checks++;
        if (to || gnt_log.size() != 2) begin failures++; $display("FAIL b2b_grants: got %0d want 2", gnt_log.size()); end
        else begin
            checks++;
            if (gnt_log[1].cyc !== gnt_log[0].cyc + 1 || gnt_log[0].port || gnt_log[1].port) begin
                failures++; $display("FAIL b2b_spacing: got cyc %0d,%0d want consecutive A grants", gnt_log[0].cyc, gnt_log[1].cyc);
            end
            foreach (gnt_log[i]) begin
                checks++;
                if ({gnt_log[i].we, gnt_log[i].re} !== {gnt_exp[i].we, gnt_exp[i].re} || gnt_log[i].addr !== 9'd7 ||
                    (gnt_log[i].we && gnt_log[i].din !== 16'hBEEF)) begin
                    failures++; $display("FAIL b2b_ram%0d: got we=%b re=%b addr=%0d din=%h want we=%b re=%b addr=7",
                        i, gnt_log[i].we, gnt_log[i].re, gnt_log[i].addr, gnt_log[i].din, gnt_exp[i].we, gnt_exp[i].re);
                end
            end
        end
        checks++;
        if (rsp_log.size() != 1 || rsp_log[0].data !== 16'hBEEF || !rsp_log[0].rv) begin
            failures++; $display("FAIL b2b_readback: got n=%0d data=%h want 1 beef", rsp_log.size(), rsp_log.size() ? rsp_log[0].data : 16'h0);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL b2b_mem: got %0d differing words want 0", bad); end
    endtask

    task automatic test_contention();
        logic to;
        clear_logs();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_cmds.push_back('{1'b1, 1'b0, 9'(i), 16'hA000 + 16'(i)});
            b_cmds.push_back('{1'b0, 1'b0, 9'(i), 16'h0});
        end
        run(to);
        checks++;
        if (to || gnt_log.size() != 8) begin failures++; $display("FAIL rr_grants: got %0d want 8", gnt_log.size()); end
        else foreach (gnt_log[i]) begin
            checks++;
            if (gnt_log[i].port !== 1'(i % 2) || gnt_log[i].cyc !== gnt_log[0].cyc + 32'(i) ||
                {gnt_log[i].we, gnt_log[i].re} !== {gnt_exp[i].we, gnt_exp[i].re} || gnt_log[i].addr !== gnt_exp[i].addr) begin
                failures++; $display("FAIL rr_grant%0d: got port=%b cyc=%0d we=%b re=%b addr=%0d want port=%0d cyc=%0d we=%b re=%b addr=%0d",
                    i, gnt_log[i].port, gnt_log[i].cyc, gnt_log[i].we, gnt_log[i].re, gnt_log[i].addr,
                    i % 2, gnt_log[0].cyc + 32'(i), gnt_exp[i].we, gnt_exp[i].re, gnt_exp[i].addr);
            end
        end
        checks++;
        if (rsp_log.size() != rsp_exp.size()) begin failures++; $display("FAIL rr_rsp_count: got %0d want %0d", rsp_log.size(), rsp_exp.size()); end
        else foreach (rsp_log[i]) begin
            checks++;
            if (rsp_log[i] !== rsp_exp[i]) begin failures++; $display("FAIL rr_rsp%0d: got %h want %h", i, rsp_log[i], rsp_exp[i]); end
        end
    endtask

    task automatic test_lock_limit();
        logic to;
        logic order [9];
        order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        clear_logs();
        do_reset();
        for (int i = 0; i < 7; i++) a_cmds.push_back('{1'b0, 1'b1, 9'(10 + i), 16'h0});
        for (int i = 0; i < 2; i++) b_cmds.push_back('{1'b0, 1'b0, 9'(20 + i), 16'h0});
        run(to);
        checks++;
        if (to || gnt_log.size() != 9) begin failures++; $display("FAIL lock_grants: got %0d want 9", gnt_log.size()); end
        else foreach (gnt_log[i]) begin
            checks++;
            if (gnt_log[i].port !== order[i] || gnt_log[i].cyc !== gnt_log[0].cyc + 32'(i)) begin
                failures++; $display("FAIL lock_grant%0d: got port=%b cyc=%0d want port=%b cyc=%0d",
                    i, gnt_log[i].port, gnt_log[i].cyc, order[i], gnt_log[0].cyc + 32'(i));
            end
        end
        checks++;
        if (rsp_log.size() != rsp_exp.size()) begin failures++; $display("FAIL lock_rsp_count: got %0d want %0d", rsp_log.size(), rsp_exp.size()); end
        else foreach (rsp_log[i]) begin
            checks++;
            if (rsp_log[i] !== rsp_exp[i]) begin failures++; $display("FAIL lock_rsp%0d: got %h want %h", i, rsp_log[i], rsp_exp[i]); end
        end
    endtask

    task automatic test_out_of_range();
        logic to;
        int bad;
        clear_logs();
        b_cmds.push_back('{1'b0, 1'b0, 9'd32, 16'h0});
        b_cmds.push_back('{1'b1, 1'b0, 9'd511, 16'hDEAD});
        run(to);
        checks++;
        if (to || gnt_log.size() != 2) begin failures++; $display("FAIL oor_grants: got %0d want 2", gnt_log.size()); end
        else foreach (gnt_log[i]) begin
            checks++;
            if (gnt_log[i].port !== 1'b1 || {gnt_log[i].we, gnt_log[i].re} !== 2'b00) begin
                failures++; $display("FAIL oor_ram%0d: got port=%b we=%b re=%b want 1 0 0", i, gnt_log[i].port, gnt_log[i].we, gnt_log[i].re);
            end
        end
        checks++;
        if (rsp_log.size() != 2) begin failures++; $display("FAIL oor_rsp_count: got %0d want 2", rsp_log.size()); end
        else begin
            checks++;
            if ({rsp_log[0].port, rsp_log[0].rv, rsp_log[0].err, rsp_log[0].data} !== {3'b111, 16'h0} ||
                {rsp_log[1].port, rsp_log[1].rv, rsp_log[1].err, rsp_log[1].data} !== {3'b101, 16'h0}) begin
                failures++; $display("FAIL oor_rsp: got %h %h want port/rv/err 111,101 data 0", rsp_log[0], rsp_log[1]);
            end
            foreach (rsp_log[i]) begin
                checks++;
                if (rsp_log[i] !== rsp_exp[i]) begin failures++; $display("FAIL oor_rsp%0d: got %h want %h", i, rsp_log[i], rsp_exp[i]); end
            end
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL oor_mem: got %0d differing words want 0", bad); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {a_req, b_req, a_we, b_we, a_lock, b_lock} = '0;
        {a_addr, b_addr, a_wdata, b_wdata} = '0;
        {ld, ld_addr, ld_data} = '0;
        rstn = 1'b0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_contention();
        test_lock_limit();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
